sram_slave_port: RTL and testbench



---
 rtl/sram_slave_port.sv | 196 +++++++++++++++++++
 tb/tb_sram_slave_port.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_slave_port.sv
// sram_slave_port
//   Byte-stream front end for a 16-bit SRAM controller. Incoming write bytes
//   are packed big-endian into a word and issued as one slave_write. Read
//   bytes are served from a 16-bit read fetch, high byte first. The low byte
//   is delivered on the following request without touching the SRAM.
//
//   Optional feature: define SRAM_PORT_TIMEOUT_EN to abandon a request after
//   255 cycles without slave_hint. The abandon is reported on timeout_err.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   wr_byte_valid/wr_byte    write byte stream; wr_byte_ready is backpressure
//   wr_flush                 zero-pad and commit a lone held byte
//   rd_byte_req              request next read byte
//   rd_byte/rd_byte_valid    read byte, one-cycle valid pulse
//   slave_write/slave_read   requests to the controller, held until slave_hint
//   slave_data_to_sram       write word (stable during a write request)
//   slave_data_from_sram     read word, sampled on slave_hint
//   slave_hint               controller completion pulse
//   fifo_i_full/fifo_o_empty controller status, informational only
//   busy                     a request is outstanding
//   timeout_err              request abandoned (timeout build only)
module sram_slave_port (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_byte_valid,
  input  logic [7:0]  wr_byte,
  output logic        wr_byte_ready,
  input  logic        wr_flush,
  input  logic        rd_byte_req,
  output logic [7:0]  rd_byte,
  output logic        rd_byte_valid,
  output logic        slave_write,
  output logic        slave_read,
  output logic [15:0] slave_data_to_sram,
  input  logic [15:0] slave_data_from_sram,
  input  logic        slave_hint,
  input  logic        fifo_i_full,
  input  logic        fifo_o_empty,
  output logic        busy,
  output logic        timeout_err
);

`ifdef SRAM_PORT_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, WAIT_TO} state_t;
`else
  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ} state_t;
`endif

  state_t      state;
  logic [15:0] wbuf;
  logic        hi_held;    // one byte of a word is held in wbuf[15:8]
  logic        word_full;  // wbuf holds a complete word awaiting write
  logic        rd_pend;    // read requested, fetch not yet served
  logic        lo_held;    // low byte of the last fetch awaits delivery
  logic [7:0]  lo_byte;
  logic        cool;       // one extra idle cycle after a hint

  // Status inputs are deliberately not used: requests stay up until the hint.
  logic unused_status;
  assign unused_status = fifo_i_full ^ fifo_o_empty;

  assign wr_byte_ready = !word_full && (state != WR_REQ);
  assign busy          = (state != IDLE);

`ifdef SRAM_PORT_TIMEOUT_EN
  logic [7:0] to_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      wbuf               <= '0;
      hi_held            <= 1'b0;
      word_full          <= 1'b0;
      rd_pend            <= 1'b0;
      lo_held            <= 1'b0;
      lo_byte            <= '0;
      cool               <= 1'b0;
      slave_write        <= 1'b0;
      slave_read         <= 1'b0;
      slave_data_to_sram <= '0;
      rd_byte            <= '0;
      rd_byte_valid      <= 1'b0;
`ifdef SRAM_PORT_TIMEOUT_EN
      to_cnt             <= '0;
      timeout_err        <= 1'b0;
`endif
    end else begin
      rd_byte_valid <= 1'b0;
`ifdef SRAM_PORT_TIMEOUT_EN
      timeout_err   <= 1'b0;
`endif

      // Byte packing. A byte arriving together with a flush completes the
      // word itself, so the flush has nothing left to pad.
      if (wr_byte_valid && wr_byte_ready) begin
        if (!hi_held) begin
          wbuf[15:8] <= wr_byte;
          hi_held    <= 1'b1;
        end else begin
          wbuf[7:0]  <= wr_byte;
          hi_held    <= 1'b0;
          word_full  <= 1'b1;
        end
      end else if (wr_flush && hi_held) begin
        wbuf[7:0] <= 8'h00;
        hi_held   <= 1'b0;
        word_full <= 1'b1;
      end

      // Read requests: serve a buffered low byte directly, else mark pending.
      if (rd_byte_req) begin
        if (lo_held) begin
          rd_byte       <= lo_byte;
          rd_byte_valid <= 1'b1;
          lo_held       <= 1'b0;
        end else if (!rd_pend) begin
          rd_pend <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          // Hint-to-request spacing: stay one more cycle idle after a hint so
          // a request never reappears on the cycle right after it dropped.
          if (cool) begin
            cool <= 1'b0;
          end else if (word_full) begin
            state              <= WR_REQ;
            slave_write        <= 1'b1;
            slave_data_to_sram <= wbuf;
`ifdef SRAM_PORT_TIMEOUT_EN
            to_cnt             <= '0;
`endif
          end else if (rd_pend) begin
            state      <= RD_REQ;
            slave_read <= 1'b1;
`ifdef SRAM_PORT_TIMEOUT_EN
            to_cnt     <= '0;
`endif
          end
        end
        WR_REQ: begin
          if (slave_hint) begin
            state       <= IDLE;
            slave_write <= 1'b0;
            word_full   <= 1'b0;
            wbuf        <= '0;
            cool        <= 1'b1;
          end
`ifdef SRAM_PORT_TIMEOUT_EN
          else if (to_cnt == 8'd254) begin
            state       <= WAIT_TO;
            slave_write <= 1'b0;
            word_full   <= 1'b0;
            wbuf        <= '0;
            timeout_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
        RD_REQ: begin
          if (slave_hint) begin
            state         <= IDLE;
            slave_read    <= 1'b0;
            rd_byte       <= slave_data_from_sram[15:8];
            rd_byte_valid <= 1'b1;
            lo_byte       <= slave_data_from_sram[7:0];
            lo_held       <= 1'b1;
            rd_pend       <= 1'b0;
            cool          <= 1'b1;
          end
`ifdef SRAM_PORT_TIMEOUT_EN
          else if (to_cnt == 8'd254) begin
            state       <= WAIT_TO;
            slave_read  <= 1'b0;
            rd_pend     <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
`endif
        end
`ifdef SRAM_PORT_TIMEOUT_EN
        WAIT_TO: state <= IDLE;
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_slave_port.sv
module tb_sram_slave_port;
  logic        clk = 1'b0;
  logic        rst;
  logic        wr_byte_valid, wr_flush, rd_byte_req, slave_hint;
  logic [7:0]  wr_byte;
  logic        wr_byte_ready, rd_byte_valid, slave_write, slave_read, busy, timeout_err;
  logic [7:0]  rd_byte;
  logic [15:0] slave_data_to_sram, slave_data_from_sram;
  logic        fifo_i_full, fifo_o_empty;

  sram_slave_port dut (
    .clk(clk), .rst(rst),
    .wr_byte_valid(wr_byte_valid), .wr_byte(wr_byte), .wr_byte_ready(wr_byte_ready),
    .wr_flush(wr_flush), .rd_byte_req(rd_byte_req), .rd_byte(rd_byte),
    .rd_byte_valid(rd_byte_valid), .slave_write(slave_write), .slave_read(slave_read),
    .slave_data_to_sram(slave_data_to_sram), .slave_data_from_sram(slave_data_from_sram),
    .slave_hint(slave_hint), .fifo_i_full(fifo_i_full), .fifo_o_empty(fifo_o_empty),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Controller model: hints after a random latency, logs every served word.
  bit          ctl_en = 1'b1;
  int          lat_min = 6, lat_max = 6;
  logic [15:0] rd_src[$];
  logic [15:0] wr_log[$];
  logic [15:0] rd_log[$];

  initial begin : ctl
    int wc, lat;
    wc = 0; lat = 1;
    slave_hint = 1'b0;
    slave_data_from_sram = '0;
    forever begin
      @(negedge clk);
      if (!ctl_en) wc = 0;
      else begin
        slave_hint = 1'b0;
        if (slave_write || slave_read) begin
          if (wc == 0) lat = $urandom_range(lat_max, lat_min);
          wc++;
          if (wc >= lat) begin
            slave_hint = 1'b1;
            wc = 0;
            if (slave_write) wr_log.push_back(slave_data_to_sram);
            else begin
              slave_data_from_sram = (rd_src.size() != 0) ? rd_src.pop_front() : 16'($urandom);
              rd_log.push_back(slave_data_from_sram);
            end
          end
        end else wc = 0;
      end
    end
  end

  // Protocol monitor: exclusivity, hint-to-request spacing, busy meaning.
  initial begin : mon
    int since;
    bit h;
    since = 99;
    forever begin
      @(posedge clk);
      h = slave_hint;
      #1;
      if (h) since = 0;
      else if (since < 99) since++;
      chk("excl", slave_write && slave_read, 0);
      chk("gap", (slave_write || slave_read) && since < 2, 0);
      chk("busy", busy, slave_write | slave_read | timeout_err);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    while (!wr_byte_ready && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) chk("ready_timeout", 0, 1);
    wr_byte_valid = 1'b1; wr_byte = b;
    @(negedge clk);
    wr_byte_valid = 1'b0;
  endtask

  task automatic flush();
    wr_flush = 1'b1;
    @(negedge clk);
    wr_flush = 1'b0;
  endtask

  task automatic rd_pulse();
    rd_byte_req = 1'b1;
    @(negedge clk);
    rd_byte_req = 1'b0;
  endtask

  task automatic wait_rd(input string tag, input logic [7:0] exp);
    int t;
    t = 0;
    while (!rd_byte_valid && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) chk({tag, "_timeout"}, 0, 1);
    else chk(tag, rd_byte, exp);
    @(negedge clk);
  endtask

  task automatic wait_wr_log(input int n);
    int t;
    t = 0;
    while (wr_log.size() < n && t < 3000) begin @(negedge clk); t++; end
  endtask

  task automatic pop_wr(input string tag, input logic [15:0] exp);
    if (wr_log.size() == 0) chk({tag, "_missing"}, 0, 1);
    else chk(tag, wr_log.pop_front(), exp);
  endtask

  task automatic wait_write_req();
    int t;
    t = 0;
    while (!slave_write && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) chk("wr_req_timeout", 0, 1);
  endtask

  logic [15:0] exp_wr[$];

  initial begin : main
    int hi;
    logic [7:0] b1, b2;
    rst = 1'b1; wr_byte_valid = 1'b0; wr_byte = '0; wr_flush = 1'b0;
    rd_byte_req = 1'b0; fifo_i_full = 1'b0; fifo_o_empty = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_write", slave_write, 0);
    chk("rst_read", slave_read, 0);
    chk("rst_data", slave_data_to_sram, 0);
    chk("rst_rdbyte", rd_byte, 0);
    chk("rst_rdvalid", rd_byte_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_terr", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", wr_byte_ready, 1);

    // A5,3C with a 6-cycle controller
    send_byte(8'hA5);
    send_byte(8'h3C);
    chk("full_not_ready", wr_byte_ready, 0);
    wait_write_req();
    chk("wr_word", slave_data_to_sram, 16'hA53C);
    hi = 0;
    while (slave_write && hi < 50) begin @(negedge clk); hi++; end
    chk("wr_hi_cycles", hi, 6);
    chk("ready_after_wr", wr_byte_ready, 1);
    pop_wr("w_a53c", 16'hA53C);

    // flush with nothing held is ignored; 7E + flush pads to 7E00
    flush();
    repeat (10) @(negedge clk);
    chk("flush_empty_nowrite", wr_log.size(), 0);
    send_byte(8'h7E);
    flush();
    wait_wr_log(1);
    pop_wr("w_flush", 16'h7E00);
    repeat (4) @(negedge clk);

    // read 1234; duplicate request while pending must not start a second read
    rd_src.push_back(16'h1234);
    rd_byte_req = 1'b1;
    repeat (2) @(negedge clk);
    rd_byte_req = 1'b0;
    wait_rd("rd_hi", 8'h12);
    rd_pulse();
    chk("rd_lo_valid", rd_byte_valid, 1);
    chk("rd_lo", rd_byte, 8'h34);
    repeat (10) @(negedge clk);
    chk("rd_single_fetch", rd_log.size(), 1);
    chk("rd_no_reissue", slave_read, 0);

    // complete word and read request on the same edge: write goes first
    lat_min = 3; lat_max = 3;
    send_byte(8'h11);
    wr_byte_valid = 1'b1; wr_byte = 8'h22; rd_byte_req = 1'b1;
    @(negedge clk);
    wr_byte_valid = 1'b0; rd_byte_req = 1'b0;
    rd_src.push_back(16'hBEEF);
    wait_rd("prio_rd_hi", 8'hBE);
    chk("prio_wr_first", wr_log.size(), 1);
    pop_wr("prio_wr", 16'h1122);
    rd_pulse();
    chk("prio_rd_lo", rd_byte, 8'hEF);
    repeat (4) @(negedge clk);

    // reset in the 3rd cycle of WR_REQ, late hint on the 5th is ignored
    ctl_en = 1'b0; slave_hint = 1'b0;
    send_byte(8'h55); send_byte(8'h66);
    wait_write_req();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstreq_write", slave_write, 0);
    chk("rstreq_busy", busy, 0);
    slave_hint = 1'b1;
    @(negedge clk);
    slave_hint = 1'b0;
    repeat (20) @(negedge clk);
    chk("rstreq_no_rewrite", slave_write, 0);
    chk("rstreq_ready", wr_byte_ready, 1);

    // controller never hints
    send_byte(8'h5A); send_byte(8'hC3);
    wait_write_req();
    hi = 0;
    while (slave_write && hi < 400) begin @(negedge clk); hi++; end
`ifdef SRAM_PORT_TIMEOUT_EN
    chk("to_cycles", hi, 255);
    chk("to_err", timeout_err, 1);
    chk("to_waitstate", busy, 1);
    @(negedge clk);
    chk("to_err_pulse", timeout_err, 0);
    chk("to_idle", busy, 0);
    chk("to_ready", wr_byte_ready, 1);
    repeat (10) @(negedge clk);
    chk("to_dropped", slave_write, 0);
`else
    chk("no_to_hold", hi, 400);
    chk("no_to_err", timeout_err, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    ctl_en = 1'b1;
    @(negedge clk);

    // randomized mixed traffic
    lat_min = 1; lat_max = 8;
    wr_log.delete(); rd_log.delete();
    fork
      begin : writer
        for (int i = 0; i < 40; i++) begin
          b1 = 8'($urandom); b2 = 8'($urandom);
          if ($urandom_range(3, 0) == 0) flush();
          send_byte(b1);
          repeat ($urandom_range(3, 0)) @(negedge clk);
          if ($urandom_range(3, 0) == 0) begin
            flush();
            exp_wr.push_back({b1, 8'h00});
          end else begin
            send_byte(b2);
            exp_wr.push_back({b1, b2});
          end
        end
      end
      begin : reader
        logic [7:0] lo;
        int nrd;
        lo = '0;
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(6, 0)) @(negedge clk);
          nrd = rd_log.size();
          rd_pulse();
          if (k % 2 == 1) begin
            chk("rnd_lo_valid", rd_byte_valid, 1);
            chk("rnd_lo", rd_byte, lo);
            chk("rnd_lo_nofetch", rd_log.size(), nrd);
          end else begin
            int t;
            t = 0;
            while (!rd_byte_valid && t < 3000) begin @(negedge clk); t++; end
            if (t >= 3000 || rd_log.size() <= k / 2) chk("rnd_hi_timeout", 0, 1);
            else begin
              chk("rnd_hi", rd_byte, rd_log[k / 2][15:8]);
              lo = rd_log[k / 2][7:0];
            end
          end
        end
      end
    join
    wait_wr_log(exp_wr.size());
    repeat (5) @(negedge clk);
    chk("rnd_wr_count", wr_log.size(), exp_wr.size());
    while (exp_wr.size() != 0) pop_wr("rnd_wr", exp_wr.pop_front());
    chk("rnd_rd_count", rd_log.size(), 15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end
endmodule
